rx_frame_proc_gen: RTL

Parametrised next-generation DCFEB packet receiver for the ODMB. It sits between the 1000BASE-X PCS/PMA 16-bit RX interface and the per-DCFEB data FIFO.
- Frames /S/-preamble-SFD-payload-CRC-/T/ packets and strips the CRC word.
- Checks CRC and both minimum and maximum length.
- Drops packets when the FIFO is full or almost full at start of packet.
- Emits a per-packet status word and saturating error counters for slow control.

---
 rtl/rx_frame_pkg.sv | 25 ++
 rtl/rx_frame_proc_gen_crc.sv | 21 ++
 rtl/rx_frame_proc_gen.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared octet codes, FSM states and status bit positions for the DCFEB frame receiver
package rx_frame_pkg;
  localparam logic [7:0] K_BC = 8'hBC;
  localparam logic [7:0] K_FB = 8'hFB;
  localparam logic [7:0] K_FD = 8'hFD;
  localparam logic [7:0] K_FE = 8'hFE;
  localparam logic [7:0] K_F7 = 8'hF7;
  localparam logic [7:0] D_55 = 8'h55;
  localparam logic [7:0] D_D5 = 8'hD5;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_DROP} state_e;
  localparam int ST_CRC   = 0;
  localparam int ST_LONG  = 1;
  localparam int ST_SHORT = 2;
  localparam int ST_CODE  = 3;
  localparam int ST_DROP  = 4;
  localparam int ST_SOP   = 5;
  localparam int ST_V     = 6;
  localparam int ST_ODD   = 7;
  function automatic logic [15:0] crc_chk(input logic [31:0] c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ~c[31-i];
    return r;
  endfunction
endpackage

// File: rtl/rx_frame_proc_gen_crc.sv
// crc32_d16: CRC-32 engine consuming 16 bits per cycle, bit 0 of the word first
module crc32_d16
  import rx_frame_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        init,
  input  logic        calc,
  input  logic        valid,
  input  logic [15:0] din,
  output logic [31:0] crc
);
  logic [31:0] crc_n;
  always_comb begin
    crc_n = crc;
    for (int i = 0; i < 16; i++) crc_n = {crc_n[30:0], 1'b0} ^ ((crc_n[31] ^ din[i]) ? CRC_POLY : 32'h0);
  end
  always_ff @(posedge CLK)
    if (!RST_N || init) crc <= '1;
    else if (calc && valid) crc <= crc_n;
endmodule

// File: rtl/rx_frame_proc_gen.sv
// rx_frame_proc_gen: 1000BASE-X 16-bit packet receiver framing DCFEB payload into the data FIFO
module rx_frame_proc_gen
  import rx_frame_pkg::*;
#(
  parameter int MAX_WORDS = 812,
  parameter int MIN_WORDS = 1,
  parameter int CNT_W     = 16,
  parameter int CRC_CHECK = 1,
  parameter int AF_DROP   = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [15:0]      RXDATA,
  input  logic [1:0]       RX_IS_K,
  input  logic [1:0]       RXDISPERR,
  input  logic [1:0]       RXNOTINTABLE,
  input  logic             FF_FULL,
  input  logic             FF_AF,
  input  logic             CNT_CLR,
  output logic [15:0]      FRM_DATA,
  output logic             FRM_DATA_VALID,
  output logic             FRM_END,
  output logic [7:0]       FRM_STATUS,
  output logic             GOOD_CRC,
  output logic             CRC_CHK_VLD,
  output logic [CNT_W-1:0] CNT_GOOD,
  output logic [CNT_W-1:0] CNT_BAD_CRC,
  output logic [CNT_W-1:0] CNT_DROP,
  output logic [CNT_W-1:0] CNT_CODE_ERR
);
  localparam int CW = $clog2(MAX_WORDS + 2);
  state_e state, state_n;
  logic [15:0] d1, hold, hold_n;
  logic k1, sop1, sopw1, eop1, odd1, v1, cerr1, cerr_in;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] acc, acc_n, cur, st;
  logic dv_n, close, feed, drop, start;
  logic [31:0] crc;
  assign cerr_in = |{RXDISPERR, RXNOTINTABLE};
  assign drop = FF_FULL || (AF_DROP != 0 && FF_AF);
  assign cur = (8'(cerr1) << ST_CODE) | (8'(v1) << ST_V);
  assign start = sop1 && (state == S_IDLE || state == S_DATA);
  assign CRC_CHK_VLD = FRM_END;
  always_ff @(posedge CLK)
    if (!RST_N) {d1, k1, sop1, sopw1, eop1, odd1, v1, cerr1} <= '0;
    else begin
      d1 <= RXDATA;
      k1 <= |RX_IS_K;
      sop1 <= RX_IS_K[0] && RXDATA[7:0] == K_FB;
      sopw1 <= RX_IS_K[1] && RXDATA[15:8] == K_FB;
      eop1 <= (RX_IS_K[0] && RXDATA[7:0] == K_FD) || (RX_IS_K[1] && RXDATA[15:8] == K_FD);
      odd1 <= RX_IS_K[1] && RXDATA[15:8] == K_FD;
      v1 <= (RX_IS_K[0] && RXDATA[7:0] == K_FE) || (RX_IS_K[1] && RXDATA[15:8] == K_FE);
      cerr1 <= cerr_in;
    end
  always_comb begin
    state_n = state;
    acc_n = acc | cur;
    st = acc | cur;
    cnt_n = cnt;
    hold_n = hold;
    dv_n = 1'b0;
    close = 1'b0;
    feed = 1'b0;
    case (state)
      S_PRE:
        if (!k1 && d1 == {D_D5, D_55}) state_n = S_DATA;
        else if (k1 || d1 != {D_55, D_55}) begin
          close = 1'b1;
          st[ST_SOP] = 1'b1;
          state_n = S_IDLE;
        end
      S_DATA:
        if (sop1 || sopw1) begin
          close = 1'b1;
          st[ST_SOP] = 1'b1;
          state_n = S_IDLE;
        end else if (eop1) begin
          close = 1'b1;
          st[ST_ODD] = odd1;
          st[ST_SHORT] = cnt < CW'(MIN_WORDS + 1);
          st[ST_CRC] = CRC_CHECK != 0 && cnt != '0 && hold != crc_chk(crc);
          state_n = S_IDLE;
        end else if (!k1 && cnt == CW'(MAX_WORDS + 1)) begin
          acc_n[ST_LONG] = 1'b1;
          state_n = S_DROP;
        end else if (!k1) begin
          hold_n = d1;
          cnt_n = cnt + CW'(1);
          dv_n = cnt != '0;
          feed = cnt != '0;
        end
      S_DROP:
        if (eop1) begin
          close = 1'b1;
          st[ST_ODD] = odd1;
          state_n = S_IDLE;
        end
      default: ;
    endcase
    if (start) begin
      cnt_n = '0;
      acc_n = cur | (drop ? 8'd1 << ST_DROP : 8'd0);
      state_n = drop ? S_DROP : S_PRE;
    end
  end
  always_ff @(posedge CLK)
    if (!RST_N) begin
      state <= S_IDLE;
      acc <= '0;
      cnt <= '0;
      hold <= '0;
      FRM_DATA <= '0;
      FRM_DATA_VALID <= 1'b0;
      FRM_END <= 1'b0;
      FRM_STATUS <= '0;
      GOOD_CRC <= 1'b1;
    end else begin
      state <= state_n;
      acc <= acc_n;
      cnt <= cnt_n;
      hold <= hold_n;
      FRM_DATA <= dv_n ? hold : FRM_DATA;
      FRM_DATA_VALID <= dv_n;
      FRM_END <= close;
      FRM_STATUS <= close ? st : FRM_STATUS;
      GOOD_CRC <= close ? !st[ST_CRC] : GOOD_CRC;
    end
  always_ff @(posedge CLK)
    if (!RST_N || CNT_CLR) {CNT_GOOD, CNT_BAD_CRC, CNT_DROP, CNT_CODE_ERR} <= '0;
    else begin
      CNT_GOOD <= CNT_GOOD + CNT_W'(close && st == '0 && !(&CNT_GOOD));
      CNT_BAD_CRC <= CNT_BAD_CRC + CNT_W'(close && st[ST_CRC] && !(&CNT_BAD_CRC));
      CNT_DROP <= CNT_DROP + CNT_W'(close && st[ST_DROP] && !(&CNT_DROP));
      CNT_CODE_ERR <= CNT_CODE_ERR + CNT_W'(cerr_in && !(&CNT_CODE_ERR));
    end
  crc32_d16 u_crc (
    .CLK(CLK),
    .RST_N(RST_N),
    .init(start),
    .calc(state == S_DATA),
    .valid(feed),
    .din(hold),
    .crc(crc)
  );
endmodule
